// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller: FSM state encoding.
package elevator_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 2'b00,
    MOVE       = 2'b01,
    DOOR_OPEN  = 2'b10,
    DOOR_CLOSE = 2'b11
  } state_e;

endpackage

// File: rtl/elevator_ctrl_fsm_req_scan.sv
// Combinational request scanner: reports whether any latched call lies ahead of
// or behind the car relative to its current travel direction.
module req_scan #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir_up,
  output logic                  ahead,
  output logic                  behind
);

  logic above;
  logic below;

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(cur_floor)) above = above | pending[i];
      if (i < int'(cur_floor)) below = below | pending[i];
    end
  end

  assign ahead  = dir_up ? above : below;
  assign behind = dir_up ? below : above;

endmodule

// File: rtl/elevator_ctrl_fsm.sv
// Registered N-floor elevator controller: latches calls, moves the car floor by
// floor with a travel timer and sequences door open/close with a door timer.
module elevator_ctrl_fsm
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 5,
  parameter int TMR_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] floor_key,
  input  logic                  door_block,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [STATE_W-1:0]    state,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [TMR_W-1:0]   TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE   = FLOOR_W'(1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      cur_floor_q, floor_d, step_floor;
  logic                    dir_up_q, dir_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    moving_q, door_open_q;

  logic                    ahead, behind;
  state_e                  dec_state;
  logic                    dec_dir;
  logic [TMR_W-1:0]        dec_tmr;

  req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_req_scan (
    .pending   (pending_q),
    .cur_floor (cur_floor_q),
    .dir_up    (dir_up_q),
    .ahead     (ahead),
    .behind    (behind)
  );

  // Shared decision rule used from IDLE and at the end of DOOR_CLOSE.
  always_comb begin
    dec_state = IDLE;
    dec_dir   = dir_up_q;
    dec_tmr   = '0;
    if (pending_q[cur_floor_q]) begin
      dec_state = DOOR_OPEN;
      dec_tmr   = DOOR_LOAD;
    end else if (ahead) begin
      dec_state = MOVE;
      dec_tmr   = TRAVEL_LOAD;
    end else if (behind) begin
      dec_state = MOVE;
      dec_dir   = ~dir_up_q;
      dec_tmr   = TRAVEL_LOAD;
    end
  end

  // Saturating step keeps the car inside 0..NUM_FLOORS-1 even on bad input.
  always_comb begin
    step_floor = cur_floor_q;
    if (dir_up_q) begin
      if (cur_floor_q != TOP_FLOOR) step_floor = cur_floor_q + FLOOR_ONE;
    end else if (cur_floor_q != '0) begin
      step_floor = cur_floor_q - FLOOR_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = cur_floor_q;
    dir_d     = dir_up_q;
    tmr_d     = tmr_q;
    pending_d = pending_q | floor_key;

    unique case (state_q)
      IDLE: begin
        state_d = dec_state;
        dir_d   = dec_dir;
        tmr_d   = dec_tmr;
      end

      MOVE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_ONE;
        end else begin
          floor_d = step_floor;
          if (pending_q[step_floor]) begin
            state_d = DOOR_OPEN;
            tmr_d   = DOOR_LOAD;
          end else begin
            tmr_d = TRAVEL_LOAD;
          end
        end
      end

      DOOR_OPEN: begin
        // Calls for the open floor are served on the spot and never stay latched.
        pending_d[cur_floor_q] = 1'b0;
        if (door_block || floor_key[cur_floor_q]) begin
          tmr_d = DOOR_LOAD;
        end else if (tmr_q == '0) begin
          state_d = DOOR_CLOSE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      DOOR_CLOSE: begin
        if (door_block) begin
          state_d = DOOR_OPEN;
          tmr_d   = DOOR_LOAD;
        end else begin
          state_d = dec_state;
          dir_d   = dec_dir;
          tmr_d   = dec_tmr;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      tmr_q       <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= floor_d;
      dir_up_q    <= dir_d;
      pending_q   <= pending_d;
      tmr_q       <= tmr_d;
      moving_q    <= (state_d == MOVE);
      door_open_q <= (state_d == DOOR_OPEN);
    end
  end

  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign state     = state_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_fsm.sv
// Directed self-checking bench for elevator_ctrl_fsm (4 floors, travel 4, door 5).
module tb_elevator_ctrl_fsm;
  import elevator_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] floor_key;
  logic       door_block;
  logic [1:0] cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [1:0] state;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  elevator_ctrl_fsm #(
    .NUM_FLOORS    (4),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (5),
    .TMR_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .floor_key  (floor_key),
    .door_block (door_block),
    .cur_floor  (cur_floor),
    .dir_up     (dir_up),
    .moving     (moving),
    .door_open  (door_open),
    .state      (state),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    floor_key  = '0;
    door_block = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_key(input logic [3:0] k);
    floor_key = k;
    tick();
    floor_key = '0;
  endtask

  task automatic wait_state(input logic [1:0] target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (state === target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
    checks++; if (cur_floor !== 2'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", cur_floor); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir: got %0b expected 1", dir_up); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %0b expected 0", moving); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %0b expected 0", door_open); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
  endtask

  task automatic test_basic_trip();
    int mv, op, cl, maxf;
    bit done;
    do_reset();
    pulse_key(4'b1000);
    checks++; if (state !== IDLE) begin errors++; $display("FAIL trip_latch_state: got %0d expected %0d", state, IDLE); end
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL trip_latch_pending: got %b expected 1000", pending); end
    mv = 0; op = 0; cl = 0; maxf = 0; done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state === MOVE) mv++;
      if (door_open === 1'b1) op++;
      if (state === DOOR_CLOSE) cl++;
      if (int'(cur_floor) > maxf) maxf = int'(cur_floor);
      if (state === IDLE) begin done = 1'b1; break; end
    end
    checks++; if (!done) begin errors++; $display("FAIL trip_timeout: got no IDLE expected IDLE within 100 cycles"); end
    checks++; if (mv != 12) begin errors++; $display("FAIL trip_move_cycles: got %0d expected 12", mv); end
    checks++; if (op != 5) begin errors++; $display("FAIL trip_open_cycles: got %0d expected 5", op); end
    checks++; if (cl != 1) begin errors++; $display("FAIL trip_close_cycles: got %0d expected 1", cl); end
    checks++; if (maxf != 3) begin errors++; $display("FAIL trip_max_floor: got %0d expected 3", maxf); end
    checks++; if (cur_floor !== 2'd3) begin errors++; $display("FAIL trip_end_floor: got %0d expected 3", cur_floor); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL trip_pending: got %b expected 0000", pending); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL trip_dir: got %0b expected 1", dir_up); end
  endtask

  task automatic test_call_at_floor();
    bit ok;
    do_reset();
    pulse_key(4'b0001);
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL here_latch: got %b expected 0001", pending); end
    tick();
    checks++; if (state !== DOOR_OPEN) begin errors++; $display("FAIL here_state: got %0d expected %0d", state, DOOR_OPEN); end
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL here_door: got %0b expected 1", door_open); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL here_moving: got %0b expected 0", moving); end
    checks++; if (cur_floor !== 2'd0) begin errors++; $display("FAIL here_floor: got %0d expected 0", cur_floor); end
    tick();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL here_clear: got %b expected 0000", pending); end
    wait_state(IDLE, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL here_idle: got state %0d expected IDLE within 30 cycles", state); end
  endtask

  task automatic test_direction();
    bit ok;
    do_reset();
    pulse_key(4'b0010);
    wait_state(DOOR_OPEN, 40, ok);
    checks++; if (!ok || cur_floor !== 2'd1) begin errors++; $display("FAIL dir_first_stop: got floor %0d ok %0b expected floor 1", cur_floor, ok); end
    pulse_key(4'b1001);
    wait_state(MOVE, 40, ok);
    checks++; if (!ok || dir_up !== 1'b1) begin errors++; $display("FAIL dir_leave_up: got dir %0b ok %0b expected dir 1", dir_up, ok); end
    wait_state(DOOR_OPEN, 40, ok);
    checks++; if (!ok || cur_floor !== 2'd3) begin errors++; $display("FAIL dir_serve_top: got floor %0d ok %0b expected floor 3", cur_floor, ok); end
    wait_state(MOVE, 40, ok);
    checks++; if (!ok || dir_up !== 1'b0) begin errors++; $display("FAIL dir_reverse: got dir %0b ok %0b expected dir 0", dir_up, ok); end
    wait_state(DOOR_OPEN, 40, ok);
    checks++; if (!ok || cur_floor !== 2'd0) begin errors++; $display("FAIL dir_serve_bottom: got floor %0d ok %0b expected floor 0", cur_floor, ok); end
    wait_state(IDLE, 40, ok);
    checks++; if (!ok || pending !== 4'b0000) begin errors++; $display("FAIL dir_done: got pending %b ok %0b expected 0000", pending, ok); end
  endtask

  task automatic test_obstruction();
    bit ok;
    int cnt;
    do_reset();
    pulse_key(4'b0001);
    wait_state(DOOR_OPEN, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL block_open: got state %0d expected DOOR_OPEN", state); end
    cnt = 1;
    door_block = 1'b1;
    repeat (10) begin
      tick();
      if (door_open === 1'b1) cnt++;
    end
    door_block = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (door_open === 1'b1) cnt++;
      else break;
    end
    checks++; if (cnt != 15) begin errors++; $display("FAIL block_open_cycles: got %0d expected 15", cnt); end
    checks++; if (state !== DOOR_CLOSE) begin errors++; $display("FAIL block_then_close: got %0d expected %0d", state, DOOR_CLOSE); end
    door_block = 1'b1;
    tick();
    door_block = 1'b0;
    checks++; if (state !== DOOR_OPEN || door_open !== 1'b1) begin errors++; $display("FAIL block_reopen: got state %0d door %0b expected state 2 door 1", state, door_open); end
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (door_open === 1'b1) cnt++;
      else break;
    end
    checks++; if (cnt != 5) begin errors++; $display("FAIL block_reopen_cycles: got %0d expected 5", cnt); end
    tick();
    checks++; if (state !== IDLE) begin errors++; $display("FAIL block_idle: got %0d expected %0d", state, IDLE); end
  endtask

  task automatic test_repress();
    bit ok;
    int cnt;
    do_reset();
    pulse_key(4'b0001);
    wait_state(DOOR_OPEN, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL repress_open: got state %0d expected DOOR_OPEN", state); end
    cnt = 1;
    repeat (3) begin
      tick();
      if (door_open === 1'b1) cnt++;
    end
    floor_key = 4'b0001;
    tick();
    floor_key = 4'b0000;
    if (door_open === 1'b1) cnt++;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL repress_absorb: got %b expected 0000", pending); end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (door_open === 1'b1) cnt++;
      else break;
    end
    checks++; if (cnt != 9) begin errors++; $display("FAIL repress_open_cycles: got %0d expected 9", cnt); end
    checks++; if (state !== DOOR_CLOSE || pending !== 4'b0000) begin errors++; $display("FAIL repress_close: got state %0d pending %b expected state 3 pending 0000", state, pending); end
    tick();
    checks++; if (state !== IDLE || pending !== 4'b0000) begin errors++; $display("FAIL repress_idle: got state %0d pending %b expected state 0 pending 0000", state, pending); end
  endtask

  task automatic test_reset_mid_move();
    bit ok;
    do_reset();
    pulse_key(4'b1000);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cur_floor === 2'd1) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok || state !== MOVE) begin errors++; $display("FAIL rst_setup: got state %0d floor %0d expected MOVE at floor 1", state, cur_floor); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== IDLE || cur_floor !== 2'd0 || dir_up !== 1'b1) begin errors++; $display("FAIL rst_async_pos: got state %0d floor %0d dir %0b expected 0 0 1", state, cur_floor, dir_up); end
    checks++; if (moving !== 1'b0 || door_open !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL rst_async_out: got moving %0b door %0b pending %b expected 0 0 0000", moving, door_open, pending); end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (state !== IDLE || cur_floor !== 2'd0) begin errors++; $display("FAIL rst_release: got state %0d floor %0d expected 0 0", state, cur_floor); end
  endtask

  initial begin
    rst_n      = 1'b0;
    floor_key  = '0;
    door_block = 1'b0;
    test_reset();
    test_basic_trip();
    test_call_at_floor();
    test_direction();
    test_obstruction();
    test_repress();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
